// File: rtl/jamma_joy_scanner.sv
// jamma_joy_scanner: time-multiplexed JAMMA two-player input scanner.
// Alternates JSELECT between player 1 and player 2, lets the external mux
// settle for SETTLE_CYC cycles, samples JJOY for one cycle, and publishes
// registered active-low player states. Coin inputs are synchronized separately.
// Optional feature macro: JOY_DEBOUNCE_EN (per-player sample debounce, DEB_CNT).
module jamma_joy_scanner #(
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned DEB_CNT    = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] JJOY,
  input  logic [5:0] JOY_LOCAL,
  input  logic [1:0] JCOIN,
  output logic       JSELECT,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic [1:0] coin,
  output logic       scan_done
);

  localparam int unsigned JOY_W   = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned N_PLAYER = 2;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  // Reject illegal parameter values at elaboration time
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("jamma_joy_scanner: SETTLE_CYC must be in 1..255");
  end
  if (DEB_CNT < 2 || DEB_CNT > 15) begin : g_bad_deb
    $error("jamma_joy_scanner: DEB_CNT must be in 2..15");
  end

  typedef enum logic [1:0] {
    S0_SETTLE = 2'd0,
    S0_SAMPLE = 2'd1,
    S1_SETTLE = 2'd2,
    S1_SAMPLE = 2'd3
  } state_t;

  state_t                          state;
  logic [CNT_W-1:0]                settle_cnt;
  logic [1:0]                      coin_meta;
  logic [N_PLAYER-1:0][JOY_W-1:0]  raw;
  logic [N_PLAYER-1:0]             sample_en;
  logic [N_PLAYER-1:0][JOY_W-1:0]  joy_q;

  // Player 1 merges the local stick into the direction/button bits; start is JAMMA only
  assign raw[0]       = JJOY & {2'b11, JOY_LOCAL};
  assign raw[1]       = JJOY;
  assign sample_en[0] = (state == S0_SAMPLE);
  assign sample_en[1] = (state == S1_SAMPLE);

  assign joy1 = joy_q[0];
  assign joy2 = joy_q[1];

  // Scan sequencer: settle, sample, swap player; JSELECT and scan_done registered here
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S0_SETTLE;
      settle_cnt <= '0;
      JSELECT    <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        S0_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= S0_SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        S0_SAMPLE: begin
          state      <= S1_SETTLE;
          settle_cnt <= '0;
          JSELECT    <= 1'b1;
        end
        S1_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= S1_SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        S1_SAMPLE: begin
          state      <= S0_SETTLE;
          settle_cnt <= '0;
          JSELECT    <= 1'b0;
          scan_done  <= 1'b1;
        end
        default: begin
          state      <= S0_SETTLE;
          settle_cnt <= '0;
          JSELECT    <= 1'b0;
        end
      endcase
    end
  end

`ifdef JOY_DEBOUNCE_EN
  localparam int unsigned DEB_W = 4;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
  localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'(DEB_CNT - 2);

  logic [N_PLAYER-1:0][JOY_W-1:0] last_q;
  logic [N_PLAYER-1:0][DEB_W-1:0] deb_q;

  // Per-player debounce: output follows a sample only after DEB_CNT identical scans
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_q <= '1;
      deb_q  <= '0;
      joy_q  <= '1;
    end else begin
      for (int p = 0; p < N_PLAYER; p++) begin
        if (sample_en[p]) begin
          if (raw[p] == last_q[p]) begin
            if (deb_q[p] != DEB_LAST) begin
              deb_q[p] <= deb_q[p] + DEB_W'(1);
            end
            // counter is about to reach (or already holds) DEB_CNT-1
            if (deb_q[p] >= DEB_LOAD) begin
              joy_q[p] <= raw[p];
            end
          end else begin
            last_q[p] <= raw[p];
            deb_q[p]  <= '0;
          end
        end
      end
    end
  end
`else
  // Direct capture: each player register loads its sample in the SAMPLE cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      joy_q <= '1;
    end else begin
      for (int p = 0; p < N_PLAYER; p++) begin
        if (sample_en[p]) begin
          joy_q[p] <= raw[p];
        end
      end
    end
  end
`endif

  // Two-flop synchronizer for the asynchronous coin switches
  always_ff @(posedge CLK) begin
    if (RESET) begin
      coin_meta <= 2'b11;
      coin      <= 2'b11;
    end else begin
      coin_meta <= JCOIN;
      coin      <= coin_meta;
    end
  end

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// tb_jamma_joy_scanner: randomized self-checking bench with a scan-timeline
// reference model (cycle index modulo scan period) and a coin delay queue.
module tb_jamma_joy_scanner;

  localparam int unsigned SETTLE = 8;
  localparam int unsigned DEB    = 4;
  localparam int unsigned PERIOD = 2 * (SETTLE + 1);

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] JJOY;
  logic [5:0] JOY_LOCAL;
  logic [1:0] JCOIN;
  logic       JSELECT;
  logic [7:0] joy1;
  logic [7:0] joy2;
  logic [1:0] coin;
  logic       scan_done;

  jamma_joy_scanner #(
    .SETTLE_CYC(SETTLE),
    .DEB_CNT   (DEB)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .JJOY     (JJOY),
    .JOY_LOCAL(JOY_LOCAL),
    .JCOIN    (JCOIN),
    .JSELECT  (JSELECT),
    .joy1     (joy1),
    .joy2     (joy2),
    .coin     (coin),
    .scan_done(scan_done)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int unsigned cyc;          // index of the cycle currently in progress since reset release
  logic [7:0]  m_joy1;
  logic [7:0]  m_joy2;
  logic        m_done;
  logic [1:0]  coin_q[$];
  logic [7:0]  prev [2];
  int          run  [2];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic m_sel();
    return (cyc % PERIOD) >= (SETTLE + 1);
  endfunction

  // Apply one player sample to the model's output value
  task automatic model_sample(input int p, input logic [7:0] s, inout logic [7:0] outv);
`ifdef JOY_DEBOUNCE_EN
    if (s == prev[p]) begin
      if (run[p] < 100) run[p]++;
    end else begin
      prev[p] = s;
      run[p]  = 1;
    end
    if (run[p] >= int'(DEB)) outv = s;
`else
    outv = s;
`endif
  endtask

  task automatic model_reset();
    cyc    = 0;
    m_joy1 = 8'hFF;
    m_joy2 = 8'hFF;
    m_done = 1'b0;
    coin_q.delete();
    for (int p = 0; p < 2; p++) begin
      prev[p] = 8'hFF;
      run[p]  = 1;
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs
  task automatic step(input logic rst, input logic [7:0] jj, input logic [5:0] loc,
                      input logic [1:0] jc);
    int unsigned ph;
    logic [1:0]  exp_coin;
    @(negedge CLK);
    RESET     = rst;
    JJOY      = jj;
    JOY_LOCAL = loc;
    JCOIN     = jc;
    @(posedge CLK);
    if (rst) begin
      model_reset();
    end else begin
      ph     = cyc % PERIOD;
      m_done = (ph == PERIOD - 1);
      if (ph == SETTLE)     model_sample(0, jj & {2'b11, loc}, m_joy1);
      if (ph == PERIOD - 1) model_sample(1, jj, m_joy2);
      coin_q.push_back(jc);
      if (coin_q.size() > 2) void'(coin_q.pop_front());
      cyc++;
    end
    exp_coin = (coin_q.size() == 2) ? coin_q[0] : 2'b11;
    #1;
    check("jselect",   8'(JSELECT),   8'(m_sel()));
    check("joy1",      joy1,          m_joy1);
    check("joy2",      joy2,          m_joy2);
    check("scan_done", 8'(scan_done), 8'(m_done));
    check("coin",      8'(coin),      8'(exp_coin));
  endtask

  // Emulate the external mux: JJOY shows the player selected in this cycle
  task automatic step_mux(input logic [7:0] p1, input logic [7:0] p2, input logic [5:0] loc,
                          input logic [1:0] jc);
    step(1'b0, m_sel() ? p2 : p1, loc, jc);
  endtask

  initial begin
    logic [7:0] p1, p2;
    logic [5:0] loc;
    int unsigned hold;
    RESET     = 1'b1;
    JJOY      = 8'hFF;
    JOY_LOCAL = 6'h3F;
    JCOIN     = 2'b11;
    model_reset();

    // Reset values
    repeat (3) step(1'b1, 8'hFF, 6'h3F, 2'b11);

    // Player 1 button 0 and player 2 start pressed
    repeat (2 * PERIOD) step_mux(8'hFE, 8'h7F, 6'h3F, 2'b11);

    // Local stick merges into player 1 only
    repeat (2 * PERIOD) step_mux(8'hFF, 8'hFF, 6'b111011, 2'b11);

    // Coin pulse of 5 cycles
    repeat (3) step_mux(8'hFF, 8'hFF, 6'h3F, 2'b11);
    repeat (5) step_mux(8'hFF, 8'hFF, 6'h3F, 2'b10);
    repeat (4) step_mux(8'hFF, 8'hFF, 6'h3F, 2'b11);

    // JJOY toggling every cycle: only SAMPLE cycles may reach the outputs
    repeat (20 * PERIOD)
      step(1'b0, 8'($urandom), 6'($urandom),
           ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11);

    // Button held for 3 scans then released, then held for 5 scans
    repeat (3 * PERIOD) step_mux(8'hFE, 8'hFF, 6'h3F, 2'b11);
    repeat (2 * PERIOD) step_mux(8'hFF, 8'hFF, 6'h3F, 2'b11);
    repeat (5 * PERIOD) step_mux(8'hFE, 8'hFF, 6'h3F, 2'b11);

    // Random player states held for a random number of scans
    for (int s = 0; s < 30; s++) begin
      p1   = 8'($urandom);
      p2   = 8'($urandom);
      loc  = 6'($urandom);
      hold = $urandom_range(1, 6);
      repeat (hold * PERIOD) step_mux(p1, p2, loc, 2'($urandom));
    end

    // Reset in S1_SETTLE with a joy2 change pending
    repeat (5 * PERIOD) step_mux(8'hFF, 8'hFF, 6'h3F, 2'b11);
    for (int i = 0; i < int'(PERIOD) && (cyc % PERIOD) != 12; i++)
      step_mux(8'hFF, 8'h55, 6'h3F, 2'b11);
    repeat (2) step(1'b1, 8'h55, 6'h3F, 2'b11);
    repeat (2 * PERIOD) step_mux(8'hFF, 8'h55, 6'h3F, 2'b11);

    // Resets at random scan phases
    for (int r = 0; r < 5; r++) begin
      hold = $urandom_range(1, 3 * PERIOD);
      repeat (hold) step_mux(8'($urandom), 8'($urandom), 6'($urandom), 2'b11);
      repeat ($urandom_range(1, 3)) step(1'b1, 8'($urandom), 6'($urandom), 2'($urandom));
      repeat (2 * PERIOD) step_mux(8'hA5, 8'h3C, 6'h2A, 2'b11);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
